// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and strobe timing controller sharing one asynchronous SRAM bank
// between N_MASTERS request/ok masters, with sub-word lanes and programmable wait states.
module sram_port_arbiter #(
    parameter int N_MASTERS   = 2,
    parameter int ADDR_W      = 20,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MASTERS-1:0]    m_req,
    input  logic [N_MASTERS-1:0]    m_we,
    input  logic [32*N_MASTERS-1:0] m_addr,
    input  logic [2*N_MASTERS-1:0]  m_size,
    input  logic [N_MASTERS-1:0]    m_unsigned,
    input  logic [32*N_MASTERS-1:0] m_wdata,
    output logic [31:0]             m_rdata,
    output logic [N_MASTERS-1:0]    m_ok,
    output logic [N_MASTERS-1:0]    m_err,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [31:0]             ram_wdata,
    input  logic [31:0]             ram_rdata,
    output logic                    ram_data_oe,
    output logic [3:0]              ram_be_n,
    output logic                    ram_ce_n,
    output logic                    ram_oe_n,
    output logic                    ram_we_n
);
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE, S_ERR} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr;
    logic [N_MASTERS-1:0]   gnt_oh;
    logic [3:0]             wait_cnt;
    logic                   we_q;
    logic                   uns_q;
    logic [1:0]             size_q;
    logic [1:0]             lane_q;

    logic                   found;
    logic [IDX_W-1:0]       pick;
    logic [N_MASTERS-1:0]   pick_oh;
    logic                   sel_we;
    logic                   sel_uns;
    logic [1:0]             sel_size;
    logic [31:0]            sel_addr;
    logic [31:0]            sel_wdata;
    logic                   sel_bad;
    int unsigned            pos;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^sel_addr[31:ADDR_W+2];

    // Offsets are scanned outermost so the first hit is the nearest master after rr.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_oh   = '0;
        sel_we    = 1'b0;
        sel_uns   = 1'b0;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        pos       = 0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            pos = (32'(rr) + 1 + i) % N_MASTERS;
            for (int unsigned j = 0; j < N_MASTERS; j++) begin
                if (!found && pos == j && m_req[j]) begin
                    found      = 1'b1;
                    pick       = IDX_W'(j);
                    pick_oh[j] = 1'b1;
                    sel_we     = m_we[j];
                    sel_uns    = m_unsigned[j];
                    sel_size   = m_size[2*j +: 2];
                    sel_addr   = m_addr[32*j +: 32];
                    sel_wdata  = m_wdata[32*j +: 32];
                end
            end
        end
        sel_bad = (sel_size == 2'b11) ||
                  (sel_size == 2'b01 && sel_addr[0]) ||
                  (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
    end

    function automatic logic [3:0] lane_be_n(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    be = 4'b1110;
                    2'd1:    be = 4'b1101;
                    2'd2:    be = 4'b1011;
                    default: be = 4'b0111;
                endcase
            end
            2'b01:   be = lane[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] d, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            rr          <= IDX_W'(N_MASTERS - 1);
            gnt_oh      <= '0;
            wait_cnt    <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= '0;
            lane_q      <= '0;
            m_rdata     <= '0;
            m_ok        <= '0;
            m_err       <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_data_oe <= 1'b0;
            ram_be_n    <= '1;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
        end else begin
            m_ok  <= '0;
            m_err <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        rr     <= pick;
                        gnt_oh <= pick_oh;
                        we_q   <= sel_we;
                        uns_q  <= sel_uns;
                        size_q <= sel_size;
                        lane_q <= sel_addr[1:0];
                        if (sel_bad) begin
                            state <= S_ERR;
                            m_ok  <= pick_oh;
                            m_err <= pick_oh;
                        end else begin
                            state       <= S_SETUP;
                            ram_ce_n    <= 1'b0;
                            ram_addr    <= sel_addr[ADDR_W+1:2];
                            ram_be_n    <= lane_be_n(sel_size, sel_addr[1:0]);
                            ram_oe_n    <= sel_we;
                            ram_data_oe <= sel_we;
                            if (sel_we)
                                ram_wdata <= lane_rep(sel_size, sel_wdata);
                        end
                    end
                end
                S_SETUP: begin
                    state    <= S_STROBE;
                    wait_cnt <= 4'(WAIT_STATES);
                    if (we_q)
                        ram_we_n <= 1'b0;
                end
                S_STROBE: begin
                    if (wait_cnt == '0) begin
                        state    <= S_DONE;
                        ram_we_n <= 1'b1;
                        m_ok     <= gnt_oh;
                        if (!we_q)
                            m_rdata <= lane_extract(ram_rdata, lane_q, size_q, uns_q);
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    ram_ce_n    <= 1'b1;
                    ram_oe_n    <= 1'b1;
                    ram_we_n    <= 1'b1;
                    ram_data_oe <= 1'b0;
                    ram_be_n    <= '1;
                end
                S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
